bp_fe_bp_update_queue: RTL and testbench

- In-order queue directly upstream of the two-level local predictor's write port (w_v_i / idx_w_i / correct_i).
- Fetch records each predicted branch (BHT index plus predicted direction) at prediction time.
- The backend later resolves branches in program order. The queue pops the oldest entry, compares the prediction with the actual outcome, and drives one registered predictor update per resolution.
- A flush squashes all unresolved entries.

---
 rtl/bp_fe_bp_update_queue.sv | 221 ++++++++++++++++++++++
 tb/tb_bp_fe_bp_update_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_bp_update_queue.sv
// ---------------------------------------------------------------------------
// bp_fe_bp_update_queue
//
// In-order queue that sits directly upstream of the two-level local
// predictor's write port. Fetch records every predicted branch (BHT index
// plus predicted direction) when the prediction is made. The backend later
// resolves branches in program order. On each accepted resolution the oldest
// entry is popped, its prediction is compared with the real outcome, and one
// registered predictor update is issued on the following cycle. A flush
// squashes every entry that was not resolved in the flush cycle.
//
// Optional feature (macro BP_UPDATE_QUEUE_STATS_EN):
//   When defined, adds saturating 16-bit counters of accepted resolves and
//   of mispredicted resolves. When undefined, those ports do not exist.
//
// Ports:
//   clk_i            clock, all state updates on posedge
//   reset_n_i        asynchronous active-low reset
//   alloc_v_i        fetch records a predicted branch this cycle
//   alloc_idx_i      BHT index used for the prediction
//   alloc_pred_i     predicted direction (1 = taken)
//   alloc_ready_o    queue can accept an allocation (not full)
//   alloc_tag_o      slot the current allocation will occupy (tail pointer)
//   resolve_v_i      oldest in-flight branch resolved this cycle
//   resolve_taken_i  actual direction
//   resolve_ready_o  queue holds at least one entry (not empty)
//   flush_i          squash all entries not resolved this cycle
//   w_v_o            predictor update valid (to w_v_i)
//   idx_w_o          predictor update index (to idx_w_i)
//   correct_o        prediction was correct (to correct_i)
//   count_o          current occupancy, 0..els_p
//   full_o           occupancy equals els_p
//   empty_o          occupancy equals zero
//   underflow_o      sticky, a resolve arrived while the queue was empty
//   resolve_cnt_o    (stats build only) accepted resolves, saturating
//   mispredict_cnt_o (stats build only) mispredicted resolves, saturating
// ---------------------------------------------------------------------------
module bp_fe_bp_update_queue #(
    parameter  int bht_idx_width_p = 9,
    parameter  int els_p           = 8,
    localparam int ptr_width_lp    = $clog2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic                       alloc_v_i,
    input  logic [bht_idx_width_p-1:0] alloc_idx_i,
    input  logic                       alloc_pred_i,
    output logic                       alloc_ready_o,
    output logic [ptr_width_lp-1:0]    alloc_tag_o,

    input  logic                       resolve_v_i,
    input  logic                       resolve_taken_i,
    output logic                       resolve_ready_o,

    input  logic                       flush_i,

    output logic                       w_v_o,
    output logic [bht_idx_width_p-1:0] idx_w_o,
    output logic                       correct_o,

    output logic [ptr_width_lp:0]      count_o,
    output logic                       full_o,
    output logic                       empty_o,
`ifdef BP_UPDATE_QUEUE_STATS_EN
    output logic                       underflow_o,
    output logic [15:0]                resolve_cnt_o,
    output logic [15:0]                mispredict_cnt_o
`else
    output logic                       underflow_o
`endif
);

    typedef struct packed {
        logic [bht_idx_width_p-1:0] idx;
        logic                       pred;
    } entry_t;

    localparam logic [ptr_width_lp:0] els_lp = (ptr_width_lp+1)'(els_p);

    entry_t                    mem_r [els_p];
    logic [ptr_width_lp-1:0]   head_r, head_next;
    logic [ptr_width_lp-1:0]   tail_r, tail_next;
    logic [ptr_width_lp:0]     count_r, count_next;

    logic                      full;
    logic                      empty;
    logic                      alloc_acc;
    logic                      resolve_acc;
    entry_t                    head_entry;
    logic                      head_correct;

    logic                      w_v_r;
    logic [bht_idx_width_p-1:0] idx_w_r;
    logic                      correct_r;
    logic                      underflow_r;

    // Full and empty come from the occupancy counter rather than from the
    // pointers, so head == tail is never ambiguous.
    assign full  = (count_r == els_lp);
    assign empty = (count_r == '0);

    // Both handshakes look only at pre-cycle state: a slot freed by a
    // same-cycle resolve cannot be reused, and an entry allocated this cycle
    // cannot be resolved until the next one.
    always_comb begin
        alloc_acc   = alloc_v_i & ~full & ~flush_i;
        resolve_acc = resolve_v_i & ~empty;
    end

    // The head entry is read combinationally and compared against the
    // resolved direction; the result is registered below.
    always_comb begin
        head_entry   = mem_r[head_r];
        head_correct = (head_entry.pred == resolve_taken_i);
    end

    // Pointer and occupancy next-state. A flush collapses head onto tail;
    // tail itself never moves on a flush because the flush-cycle alloc is
    // always dropped. Flushing an empty queue leaves head == tail anyway.
    always_comb begin
        tail_next  = tail_r;
        head_next  = head_r;
        count_next = count_r;
        if (alloc_acc) begin
            tail_next = tail_r + ptr_width_lp'(1);
        end
        if (flush_i) begin
            head_next  = tail_r;
            count_next = '0;
        end else begin
            if (resolve_acc) begin
                head_next = head_r + ptr_width_lp'(1);
            end
            count_next = count_r
                       + (ptr_width_lp+1)'(alloc_acc)
                       - (ptr_width_lp+1)'(resolve_acc);
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            head_r  <= head_next;
            tail_r  <= tail_next;
            count_r <= count_next;
        end
    end

    // Entry storage has no reset; a slot is only ever read after it has
    // been written by an accepted allocation.
    always_ff @(posedge clk_i) begin
        if (alloc_acc) begin
            mem_r[tail_r] <= '{idx: alloc_idx_i, pred: alloc_pred_i};
        end
    end

    // Registered predictor update. w_v is a one-cycle pulse per accepted
    // resolve; index and correctness hold their last values while idle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_v_r     <= 1'b0;
            idx_w_r   <= '0;
            correct_r <= 1'b0;
        end else begin
            w_v_r <= resolve_acc;
            if (resolve_acc) begin
                idx_w_r   <= head_entry.idx;
                correct_r <= head_correct;
            end
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            underflow_r <= 1'b0;
        end else if (resolve_v_i && empty) begin
            underflow_r <= 1'b1;
        end
    end

`ifdef BP_UPDATE_QUEUE_STATS_EN
    logic [15:0] resolve_cnt_r;
    logic [15:0] mispredict_cnt_r;

    // Saturating statistics counters; flush has no effect on them.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            resolve_cnt_r    <= '0;
            mispredict_cnt_r <= '0;
        end else if (resolve_acc) begin
            if (resolve_cnt_r != 16'hFFFF) begin
                resolve_cnt_r <= resolve_cnt_r + 16'd1;
            end
            if (!head_correct && (mispredict_cnt_r != 16'hFFFF)) begin
                mispredict_cnt_r <= mispredict_cnt_r + 16'd1;
            end
        end
    end

    assign resolve_cnt_o    = resolve_cnt_r;
    assign mispredict_cnt_o = mispredict_cnt_r;
`endif

    assign alloc_ready_o   = ~full;
    assign alloc_tag_o     = tail_r;
    assign resolve_ready_o = ~empty;
    assign w_v_o           = w_v_r;
    assign idx_w_o         = idx_w_r;
    assign correct_o       = correct_r;
    assign count_o         = count_r;
    assign full_o          = full;
    assign empty_o         = empty;
    assign underflow_o     = underflow_r;

endmodule

// File: tb/tb_bp_fe_bp_update_queue.sv
// ---------------------------------------------------------------------------
// tb_bp_fe_bp_update_queue
//
// Self-checking bench for bp_fe_bp_update_queue. A table of directed
// vectors (inputs plus hand-computed expected outputs after the clock edge)
// covers the basic update path, fill to full, and simultaneous
// alloc/resolve. Hand-written sequences cover flush, underflow, mid-stream
// asynchronous reset and pointer wrap. Define BP_UPDATE_QUEUE_STATS_EN to
// also check the statistics counters.
// ---------------------------------------------------------------------------
module tb_bp_fe_bp_update_queue;

    localparam int IW = 9;
    localparam int PW = 3;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          alloc_v_i;
    logic [IW-1:0] alloc_idx_i;
    logic          alloc_pred_i;
    logic          alloc_ready_o;
    logic [PW-1:0] alloc_tag_o;
    logic          resolve_v_i;
    logic          resolve_taken_i;
    logic          resolve_ready_o;
    logic          flush_i;
    logic          w_v_o;
    logic [IW-1:0] idx_w_o;
    logic          correct_o;
    logic [PW:0]   count_o;
    logic          full_o;
    logic          empty_o;
    logic          underflow_o;
`ifdef BP_UPDATE_QUEUE_STATS_EN
    logic [15:0]   resolve_cnt_o;
    logic [15:0]   mispredict_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          av;
        logic [IW-1:0] aidx;
        logic          apred;
        logic          rv;
        logic          rt;
        logic          fl;
        logic          e_wv;
        logic [IW-1:0] e_idx;
        logic          e_cor;
        logic [PW:0]   e_cnt;
        logic          e_full;
    } vec_t;

    vec_t vecs[$];

    bp_fe_bp_update_queue #(
        .bht_idx_width_p(IW),
        .els_p(8)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .alloc_v_i       (alloc_v_i),
        .alloc_idx_i     (alloc_idx_i),
        .alloc_pred_i    (alloc_pred_i),
        .alloc_ready_o   (alloc_ready_o),
        .alloc_tag_o     (alloc_tag_o),
        .resolve_v_i     (resolve_v_i),
        .resolve_taken_i (resolve_taken_i),
        .resolve_ready_o (resolve_ready_o),
        .flush_i         (flush_i),
        .w_v_o           (w_v_o),
        .idx_w_o         (idx_w_o),
        .correct_o       (correct_o),
        .count_o         (count_o),
        .full_o          (full_o),
        .empty_o         (empty_o),
`ifdef BP_UPDATE_QUEUE_STATS_EN
        .underflow_o     (underflow_o),
        .resolve_cnt_o   (resolve_cnt_o),
        .mispredict_cnt_o(mispredict_cnt_o)
`else
        .underflow_o     (underflow_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void addVec(input logic av, input logic [IW-1:0] aidx,
                                   input logic apred, input logic rv,
                                   input logic rt, input logic fl,
                                   input logic e_wv, input logic [IW-1:0] e_idx,
                                   input logic e_cor, input int e_cnt,
                                   input logic e_full);
        vec_t v;
        v.av = av; v.aidx = aidx; v.apred = apred;
        v.rv = rv; v.rt = rt; v.fl = fl;
        v.e_wv = e_wv; v.e_idx = e_idx; v.e_cor = e_cor;
        v.e_cnt = (PW+1)'(e_cnt); v.e_full = e_full;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic av, input logic [IW-1:0] aidx,
                                 input logic apred, input logic rv,
                                 input logic rt, input logic fl);
        alloc_v_i       = av;
        alloc_idx_i     = aidx;
        alloc_pred_i    = apred;
        resolve_v_i     = rv;
        resolve_taken_i = rt;
        flush_i         = fl;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n_i       = 1'b0;
        alloc_v_i       = 1'b0;
        alloc_idx_i     = '0;
        alloc_pred_i    = 1'b0;
        resolve_v_i     = 1'b0;
        resolve_taken_i = 1'b0;
        flush_i         = 1'b0;

        // Basic update: mispredicted taken branch.
        addVec(1, 9'h005, 1, 0, 0, 0,   0, 9'h000, 0, 1, 0);
        addVec(0, 9'h000, 0, 1, 0, 0,   1, 9'h005, 0, 0, 0);
        addVec(0, 9'h000, 0, 0, 0, 0,   0, 9'h005, 0, 0, 0);
        // Fill with idx 0..7, then a rejected 9th alloc.
        for (int i = 0; i < 8; i++)
            addVec(1, IW'(i), i[0], 0, 0, 0,   0, 9'h005, 0, i + 1, i == 7);
        addVec(1, 9'h1FF, 1, 0, 0, 0,   0, 9'h005, 0, 8, 1);
        // Drain in order with correct predictions.
        for (int i = 0; i < 8; i++)
            addVec(0, 9'h000, 0, 1, i[0], 0,   1, IW'(i), 1, 7 - i, 0);
        // Refill (pred 0), then alloc+resolve while full.
        for (int i = 0; i < 8; i++)
            addVec(1, IW'(9'h010 + i), 0, 0, 0, 0,   0, 9'h007, 1, i + 1, i == 7);
        addVec(1, 9'h1AA, 1, 1, 0, 0,   1, 9'h010, 1, 7, 0);
        for (int i = 1; i <= 4; i++)
            addVec(0, 9'h000, 0, 1, 1, 0,   1, IW'(9'h010 + i), 0, 7 - i, 0);
        // At count 3: alloc+resolve keeps count at 3.
        addVec(1, 9'h020, 1, 1, 0, 0,   1, 9'h015, 1, 3, 0);
        addVec(0, 9'h000, 0, 1, 1, 0,   1, 9'h016, 0, 2, 0);
        addVec(0, 9'h000, 0, 1, 1, 0,   1, 9'h017, 0, 1, 0);
        addVec(0, 9'h000, 0, 1, 1, 0,   1, 9'h020, 1, 0, 0);
        addVec(0, 9'h000, 0, 0, 0, 0,   0, 9'h020, 1, 0, 0);

        // Reset state.
        #12;
        checkOutput("rst_w_v", 32'(w_v_o), 0);
        checkOutput("rst_idx", 32'(idx_w_o), 0);
        checkOutput("rst_correct", 32'(correct_o), 0);
        checkOutput("rst_count", 32'(count_o), 0);
        checkOutput("rst_empty", 32'(empty_o), 1);
        checkOutput("rst_full", 32'(full_o), 0);
        checkOutput("rst_underflow", 32'(underflow_o), 0);
        checkOutput("rst_tag", 32'(alloc_tag_o), 0);
        checkOutput("rst_alloc_ready", 32'(alloc_ready_o), 1);
        checkOutput("rst_resolve_ready", 32'(resolve_ready_o), 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // Table-driven vectors.
        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].av, vecs[k].aidx, vecs[k].apred,
                          vecs[k].rv, vecs[k].rt, vecs[k].fl);
            checkOutput($sformatf("vec%0d_w_v", k), 32'(w_v_o), 32'(vecs[k].e_wv));
            checkOutput($sformatf("vec%0d_idx", k), 32'(idx_w_o), 32'(vecs[k].e_idx));
            checkOutput($sformatf("vec%0d_correct", k), 32'(correct_o), 32'(vecs[k].e_cor));
            checkOutput($sformatf("vec%0d_count", k), 32'(count_o), 32'(vecs[k].e_cnt));
            checkOutput($sformatf("vec%0d_full", k), 32'(full_o), 32'(vecs[k].e_full));
            checkOutput($sformatf("vec%0d_alloc_ready", k), 32'(alloc_ready_o),
                        32'(!vecs[k].e_full));
            checkOutput($sformatf("vec%0d_empty", k), 32'(empty_o),
                        32'(vecs[k].e_cnt == 0));
        end

        // Flush with a same-cycle resolve; 18 allocs so far leave tail at 2.
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, IW'(9'h030 + i), 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_pre_count", 32'(count_o), 5);
        applyStimulus(1'b1, 9'h03F, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("flush_w_v", 32'(w_v_o), 1);
        checkOutput("flush_idx", 32'(idx_w_o), 32'h030);
        checkOutput("flush_correct", 32'(correct_o), 1);
        checkOutput("flush_count", 32'(count_o), 0);
        checkOutput("flush_empty", 32'(empty_o), 1);
        checkOutput("flush_tag", 32'(alloc_tag_o), 7);
        idle();
        checkOutput("flush_single_pulse", 32'(w_v_o), 0);
        applyStimulus(1'b1, 9'h040, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("post_flush_tag_wrap", 32'(alloc_tag_o), 0);
        checkOutput("post_flush_count", 32'(count_o), 1);
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("post_flush_w_v", 32'(w_v_o), 1);
        checkOutput("post_flush_idx", 32'(idx_w_o), 32'h040);
        checkOutput("post_flush_correct", 32'(correct_o), 1);

        // Resolve while empty.
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("uf_w_v", 32'(w_v_o), 0);
        checkOutput("uf_flag", 32'(underflow_o), 1);
        checkOutput("uf_count", 32'(count_o), 0);
        idle();
        checkOutput("uf_sticky", 32'(underflow_o), 1);
        // Alloc+resolve while empty: alloc taken, resolve ignored.
        applyStimulus(1'b1, 9'h045, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("empty_pair_w_v", 32'(w_v_o), 0);
        checkOutput("empty_pair_count", 32'(count_o), 1);
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("empty_pair_pop_idx", 32'(idx_w_o), 32'h045);
        checkOutput("empty_pair_pop_w_v", 32'(w_v_o), 1);

        // Mid-stream asynchronous reset with 4 entries queued.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, IW'(9'h050 + i), 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'h054, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("pre_reset_w_v", 32'(w_v_o), 1);
        checkOutput("pre_reset_count", 32'(count_o), 4);
        idle();
        #2;
        reset_n_i = 1'b0;
        #1;
        checkOutput("async_rst_w_v", 32'(w_v_o), 0);
        checkOutput("async_rst_idx", 32'(idx_w_o), 0);
        checkOutput("async_rst_correct", 32'(correct_o), 0);
        checkOutput("async_rst_count", 32'(count_o), 0);
        checkOutput("async_rst_underflow", 32'(underflow_o), 0);
        checkOutput("async_rst_empty", 32'(empty_o), 1);
        checkOutput("async_rst_tag", 32'(alloc_tag_o), 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // Twenty alloc/resolve pairs across the pointer wrap.
        for (int i = 0; i < 20; i++) begin
            logic p, t;
            p = i[0];
            t = i[1];
            applyStimulus(1'b1, IW'(9'h060 + i), p, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 9'h000, 1'b0, 1'b1, t, 1'b0);
            checkOutput($sformatf("wrap%0d_w_v", i), 32'(w_v_o), 1);
            checkOutput($sformatf("wrap%0d_idx", i), 32'(idx_w_o), 32'(9'h060 + i));
            checkOutput($sformatf("wrap%0d_correct", i), 32'(correct_o), 32'(p == t));
        end
        checkOutput("wrap_tag", 32'(alloc_tag_o), 4);
        checkOutput("wrap_count", 32'(count_o), 0);
`ifdef BP_UPDATE_QUEUE_STATS_EN
        checkOutput("stats_resolve_cnt", 32'(resolve_cnt_o), 20);
        checkOutput("stats_mispredict_cnt", 32'(mispredict_cnt_o), 10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
